add_scheduler: RTL and testbench

ADD_SCHEDULER -- requirements
Module: add_scheduler

---
 rtl/add_scheduler_pkg.sv | 14 +
 rtl/slice_adder.sv | 15 +
 rtl/add_scheduler.sv | 116 +++++++++++
 tb/tb_add_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_scheduler_pkg.sv
// Shared definitions for the add_scheduler block: the FSM state encoding
// and the default operand and slice widths.
package add_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 8;

endpackage

// File: rtl/slice_adder.sv
// Single SLICE-bit combinational adder with carry in and carry out.
// It is the only adder in the scheduler and is reused on every slice.
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/add_scheduler.sv
// Round-robin arbiter that shares one SLICE-bit adder among NREQ requesters,
// computing each WIDTH-bit sum serially over WIDTH/SLICE cycles.
module add_scheduler
  import add_scheduler_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_opa,
  input  logic [NREQ*WIDTH-1:0]    req_opb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDW    = $clog2(NREQ);
  localparam logic [KW-1:0]  K_LAST  = KW'(NSLICE - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, id, grant_id;
  logic             grant_any;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] opa, opb, sum;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  // First valid requester at or after start, searching cyclically.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  start);
    logic [IDW:0] pick;
    int idx;
    pick = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = (int'(start) + j) % NREQ;
      if (valid[idx]) pick = {1'b1, IDW'(idx)};
    end
    return pick;
  endfunction

  assign {grant_any, grant_id} = rr_pick(req_valid, ptr);

  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a    (opa[k*SLICE +: SLICE]),
    .b    (opb[k*SLICE +: SLICE]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: if (grant_any && !rst) begin
        req_ready[grant_id] = 1'b1;
        state_nxt           = ADD;
      end
      ADD:  if (k == K_LAST) state_nxt = RESP;
      RESP: if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, serial slice accumulation and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      k     <= '0;
      carry <= 1'b0;
      id    <= '0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          opa   <= req_opa[grant_id*WIDTH +: WIDTH];
          opb   <= req_opb[grant_id*WIDTH +: WIDTH];
          id    <= grant_id;
          k     <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          sum[k*SLICE +: SLICE] <= slice_sum;
          carry                 <= slice_cout;
          k                     <= (k == K_LAST) ? '0 : k + KW'(1);
        end
        RESP: if (rsp_ready) ptr <= (id == ID_LAST) ? '0 : id + IDW'(1);
        default: ;
      endcase
    end
  end

  // Outputs read as idle while reset is held, even before the reset edge lands.
  assign rsp_valid = (state == RESP) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign rsp_id    = rst ? '0 : id;
  assign rsp_sum   = rst ? '0 : sum;
  assign rsp_carry = rst ? 1'b0 : carry;

endmodule

// File: tb/tb_add_scheduler.sv
// Bench for add_scheduler: directed scenarios plus a randomized run scored
// against a cycle-level reference of grants, latency and sums.
module tb_add_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int S  = 8;
  localparam int NS = W / S;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_opa;
  logic [N*W-1:0]   req_opb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;
  logic             busy;

  int checks = 0;
  int fails  = 0;
  int mptr   = 0;

  always #5 clk = ~clk;

  add_scheduler #(.NREQ(N), .WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input int p);
    logic [N-1:0] one;
    one = 1;
    for (int j = 0; j < N; j++) begin
      if (v[(p + j) % N]) return one << ((p + j) % N);
    end
    return '0;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drain(input int exp_id);
    bit done;
    done = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (rsp_valid) begin
        mptr = (exp_id + 1) % N;
        @(negedge clk);
        done = 1;
        break;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (!done) begin fails++; $display("FAIL drain_timeout: no response within 30 cycles"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++;
    if ({rsp_valid, busy, rsp_carry, rsp_id, rsp_sum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b busy=%b carry=%b id=%0d sum=%h want all 0",
               rsp_valid, busy, rsp_carry, rsp_id, rsp_sum);
    end
    rst = 1'b0; req_valid = '0; mptr = 0;
  endtask

  task automatic test_carry_chain();
    int lat;
    lat = 0;
    req_opa[W-1:0] = 32'hFFFF_FFFF; req_opb[W-1:0] = 32'h0000_0001;
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL carry_grant: got %b want 0001", req_ready); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = '0;
      if (rsp_valid) begin lat = c; break; end
    end
    checks++;
    if (lat != NS + 1) begin fails++; $display("FAIL carry_latency: got %0d want %0d", lat, NS + 1); end
    checks++;
    if (rsp_sum !== 32'h0 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL carry_result: sum=%h carry=%b id=%0d want 00000000/1/0", rsp_sum, rsp_carry, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    mptr = 1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL carry_release: valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int g, last, lastgid;
    logic [N-1:0] one, exp;
    logic [W:0] esum [N];
    one = 1;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; mptr = 0;
    for (int i = 0; i < N; i++) begin
      req_opa[i*W +: W] = $urandom;
      req_opb[i*W +: W] = $urandom;
      esum[i] = {1'b0, req_opa[i*W +: W]} + {1'b0, req_opb[i*W +: W]};
    end
    req_valid = '1; rsp_ready = 1'b1;
    g = 0; last = 0; lastgid = 0;
    for (int c = 0; c < 60 && g < 5; c++) begin
      #1;
      if (req_ready !== '0) begin
        exp = one << (g % N);
        checks++;
        if (req_ready !== exp) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp); end
        if (g > 0) begin
          checks++;
          if (c - last != 6) begin fails++; $display("FAIL rr_interval: got %0d want 6", c - last); end
        end
        last = c; lastgid = g % N; g++;
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== 2'(lastgid) || {rsp_carry, rsp_sum} !== esum[lastgid]) begin
          fails++;
          $display("FAIL rr_result: id=%0d sum=%h carry=%b want id=%0d %h", rsp_id, rsp_sum, rsp_carry,
                   lastgid, esum[lastgid]);
        end
        mptr = (lastgid + 1) % N;
      end
      @(negedge clk);
    end
    checks++;
    if (g != 5) begin fails++; $display("FAIL rr_count: got %0d grants want 5", g); end
    drain(0);
  endtask

  task automatic test_backpressure();
    int lat;
    lat = 0;
    req_opa[2*W +: W] = 32'h1234_5678; req_opb[2*W +: W] = 32'h0F0F_0F0F;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = '1;
      if (rsp_valid) begin lat = c; break; end
    end
    checks++;
    if (lat != NS + 1) begin fails++; $display("FAIL bp_latency: got %0d want %0d", lat, NS + 1); end
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2143_6587 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin
        fails++;
        $display("FAIL bp_hold: valid=%b sum=%h carry=%b id=%0d want 1/21436587/0/2",
                 rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      checks++;
      if (req_ready !== '0) begin fails++; $display("FAIL bp_ready: got %b want 0000", req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0; mptr = 3;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_release: valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_add();
    logic [W:0] e;
    int lat;
    lat = 0;
    for (int i = 0; i < N; i++) begin req_opa[i*W +: W] = $urandom; req_opb[i*W +: W] = $urandom; end
    e = {1'b0, req_opa[W +: W]} + {1'b0, req_opb[W +: W]};
    req_valid = 4'b1110; rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== rr_model(4'b1110, mptr)) begin
      fails++; $display("FAIL rst_first_grant: got %b want %b", req_ready, rr_model(4'b1110, mptr));
    end
    @(negedge clk);
    req_valid = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
      fails++; $display("FAIL rst_abort: busy=%b valid=%b ready=%b want 0/0/0000", busy, rsp_valid, req_ready);
    end
    rst = 1'b0; mptr = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL rst_regrant: got %b want 0010", req_ready); end
    rsp_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = '0;
      if (rsp_valid) begin lat = c; break; end
    end
    checks++;
    if (lat != NS + 1 || rsp_id !== 2'd1 || {rsp_carry, rsp_sum} !== e) begin
      fails++;
      $display("FAIL rst_result: lat=%0d id=%0d sum=%h carry=%b want %0d/1/%h", lat, rsp_id, rsp_sum,
               rsp_carry, NS + 1, e);
    end
    @(negedge clk);
    rsp_ready = 1'b0; mptr = 2;
  endtask

  task automatic test_back_to_back();
    int g, r, last;
    req_opa[3*W +: W] = 32'h8000_0000; req_opb[3*W +: W] = 32'h8000_0000;
    req_valid = 4'b1000; rsp_ready = 1'b1;
    g = 0; r = 0; last = 0;
    for (int c = 0; c < 40 && r < 2; c++) begin
      #1;
      if (req_ready !== '0) begin
        checks++;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL b2b_grant: got %b want 1000", req_ready); end
        if (g > 0) begin
          checks++;
          if (c - last != 6) begin fails++; $display("FAIL b2b_interval: got %0d want 6", c - last); end
        end
        last = c; g++;
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_sum !== 32'h0 || rsp_carry !== 1'b1 || rsp_id !== 2'd3) begin
          fails++;
          $display("FAIL b2b_result: sum=%h carry=%b id=%0d want 00000000/1/3", rsp_sum, rsp_carry, rsp_id);
        end
        r++; mptr = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (r != 2) begin fails++; $display("FAIL b2b_count: got %0d responses want 2", r); end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL b2b_wrap: got %b want 0001", req_ready); end
    @(negedge clk);
    drain(0);
  endtask

  task automatic test_random();
    bit inflight;
    int age, eid;
    logic [N-1:0] exp;
    logic [W:0] esum;
    inflight = 0; age = 0; eid = 0; esum = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) begin req_opa[i*W +: W] = $urandom; req_opb[i*W +: W] = $urandom; end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!inflight) begin
        exp = rr_model(req_valid, mptr);
        checks++;
        if (req_ready !== exp) begin
          fails++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, req_ready, exp);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL rand_idle: cycle %0d valid=%b busy=%b want 0/0", c, rsp_valid, busy);
        end
        if (exp != '0) begin
          eid = idx_of(exp);
          esum = {1'b0, req_opa[eid*W +: W]} + {1'b0, req_opb[eid*W +: W]};
          inflight = 1; age = 0;
        end
      end else begin
        age++;
        checks++;
        if (req_ready !== '0) begin fails++; $display("FAIL rand_ready_busy: cycle %0d got %b want 0", c, req_ready); end
        if (age <= NS) begin
          checks++;
          if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL rand_add: cycle %0d valid=%b busy=%b want 0/1", c, rsp_valid, busy);
          end
        end else begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid) || {rsp_carry, rsp_sum} !== esum) begin
            fails++;
            $display("FAIL rand_resp: cycle %0d valid=%b id=%0d sum=%h carry=%b want 1/%0d/%h",
                     c, rsp_valid, rsp_id, rsp_sum, rsp_carry, eid, esum);
          end
          if (rsp_ready) begin inflight = 0; mptr = (eid + 1) % N; end
        end
      end
      @(negedge clk);
    end
    if (inflight) drain(eid);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_opa = '0; req_opb = '0;
    @(negedge clk);
    test_reset();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_reset_mid_add();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
